log2_approx_pipe: RTL

- Pipelined, parametrised successor to the combinational log2 approximation unit.
- Computes the Mitchell approximation of log2(x) on signed fixed-point input QI.F, where F = FRAC_W and I = DATA_W-FRAC_W.
- Returns the result in the same Q format, with error and saturation flags.
- Sits in the softmax/normalisation datapath behind a valid/ready stream interface, so it can stall with downstream consumers.

---
 rtl/log2_approx_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/log2_approx_pipe.sv
// log2_approx_pipe
//   Pipelined Mitchell approximation of log2(x) on a signed fixed-point
//   operand in QI.F format, where F = FRAC_W and I = DATA_W-FRAC_W. The
//   result uses the same Q format. A valid/ready stream wraps three register
//   stages that all advance together. Latency is 3 cycles when nothing stalls.
//
//   Optional feature macro: LOG2_CORR_EN
//     When defined, S3 adds a piecewise-linear correction term before
//     saturation. When undefined, the result is pure Mitchell and no
//     correction logic exists.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     in_valid   in_x is valid this cycle
//     in_ready   block accepts in_x this cycle
//     in_x       signed QI.F operand
//     out_valid  out_log2 and flags are valid
//     out_ready  downstream accepts the output
//     out_log2   signed QI.F result
//     out_err    operand was <= 0 (result forced to the most-negative value)
//     out_sat    result clamped to the most-negative value
module log2_approx_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_log2,
  output logic                     out_err,
  output logic                     out_sat
);

  localparam int PW = $clog2(DATA_W);
  // Headroom so that (p - FRAC_W) << FRAC_W never wraps before the clamp.
  localparam int RW = DATA_W + 3;
  localparam logic signed [RW-1:0] FRAC_S  = RW'(FRAC_W);
  localparam logic signed [RW-1:0] SAT_LIM = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]    MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // Position of the highest set bit below the sign bit. Only meaningful
  // for positive operands; other inputs are flagged as errors.
  function automatic logic [PW-1:0] lead_one(input logic [DATA_W-1:0] x);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W-1; i++) begin
      if (x[i]) p = PW'(i);
    end
    return p;
  endfunction

`ifdef LOG2_CORR_EN
  // Triangular correction peaking at f = 0.5: min(f, 1-f) / 4.
  function automatic logic [RW-1:0] corr_fn(input logic [FRAC_W-1:0] f);
    logic [RW-1:0] fe;
    logic [RW-1:0] half;
    logic [RW-1:0] full;
    logic [RW-1:0] m;
    fe   = RW'(f);
    half = RW'(1) << (FRAC_W-1);
    full = RW'(1) << FRAC_W;
    m    = (fe < half) ? fe : (full - fe);
    return m >> 2;
  endfunction
`endif

  // Returns {err, sat, value}. The error case takes priority over the clamp.
  function automatic logic [DATA_W+1:0] sat_fn(input logic signed [RW-1:0] raw,
                                               input logic err);
    if (err)                 return {1'b1, 1'b0, MOST_NEG};
    else if (raw < SAT_LIM)  return {1'b0, 1'b1, MOST_NEG};
    else                     return {1'b0, 1'b0, raw[DATA_W-1:0]};
  endfunction

  logic                     adv;

  logic                     vld_p1_q, vld_p2_q;
  logic signed [DATA_W-1:0] x_p1_q;
  logic [PW-1:0]            p_p1_q, p_p1_d;
  logic                     err_p1_q, err_p1_d;

  logic [PW-1:0]            p_p2_q;
  logic                     err_p2_q;
  logic [FRAC_W-1:0]        f_p2_q, f_p2_d;
  logic [PW-1:0]            shamt_p1;

  logic signed [RW-1:0]     raw_p2;
  logic [DATA_W+1:0]        res_p2;

  logic                     out_valid_q;
  logic [DATA_W-1:0]        out_log2_q, out_log2_d;
  logic                     out_err_q, out_err_d;
  logic                     out_sat_q, out_sat_d;

  // A single advance for every stage: bubbles are kept, never collapsed.
  always_comb begin
    adv = !out_valid_q || out_ready;
  end

  // ---- S1 input: leading-one position and zero/negative detect
  always_comb begin
    p_p1_d   = lead_one(in_x);
    err_p1_d = in_x[DATA_W-1] || (in_x == '0);
  end

  // ---- S2 input: normalise so the leading one sits at the sign position;
  // the FRAC_W bits just below it form the Mitchell fraction.
  always_comb begin
    shamt_p1 = PW'(DATA_W-1) - p_p1_q;
    f_p2_d   = FRAC_W'((x_p1_q << shamt_p1) >> (DATA_W-1-FRAC_W));
  end

  // ---- S3 input: assemble integer and fractional parts, then clamp
  always_comb begin
    raw_p2 = ((signed'(RW'(p_p2_q)) - FRAC_S) <<< FRAC_W) + signed'(RW'(f_p2_q));
`ifdef LOG2_CORR_EN
    raw_p2 = raw_p2 + signed'(corr_fn(f_p2_q));
`endif
    res_p2     = sat_fn(raw_p2, err_p2_q);
    out_err_d  = res_p2[DATA_W+1];
    out_sat_d  = res_p2[DATA_W];
    out_log2_d = res_p2[DATA_W-1:0];
  end

  // Control and output registers. Outputs are cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_log2_q  <= '0;
      out_err_q   <= 1'b0;
      out_sat_q   <= 1'b0;
    end else if (adv) begin
      vld_p1_q    <= in_valid;
      vld_p2_q    <= vld_p1_q;
      out_valid_q <= vld_p2_q;
      out_log2_q  <= out_log2_d;
      out_err_q   <= out_err_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // Internal datapath registers. These only move with the shared advance.
  always_ff @(posedge clk) begin
    if (adv) begin
      x_p1_q   <= in_x;
      p_p1_q   <= p_p1_d;
      err_p1_q <= err_p1_d;
      p_p2_q   <= p_p1_q;
      err_p2_q <= err_p1_q;
      f_p2_q   <= f_p2_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_log2  = out_log2_q;
  assign out_err   = out_err_q;
  assign out_sat   = out_sat_q;

endmodule
